cache_mem_arbiter: RTL and testbench

- Arbitrates the single memory-controller RAM port between the icache and dcache request channels.
- Sits between the two caches and the RAM-side interface; it owns grant sequencing, word-level handshakes and dcache burst locking.
- Policy is dcache-priority, with a starvation counter that bounds icache wait, and a lock that keeps multi-word dcache block transfers atomic.

---
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single RAM port between the icache and the dcache.
// The dcache has priority. A starvation counter forces the icache in after
// MAX_DWIN consecutive dcache grants. A dcache lock keeps a multi-word block
// transfer on the port until its last word completes.
module cache_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_DWIN = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache channel
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] iload,
  output logic              iwait,
  // dcache channel
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  input  logic              dlock,
  output logic [ADDR_W-1:0] dload,
  output logic              dwait,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IGNT = 2'd1;
  localparam logic [1:0] DGNT = 2'd2;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DWIN);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] arb_state;
  logic [3:0] starve_cnt;
  logic [3:0] cnt_next;
  logic       drq;
  logic       complete;
  logic       burst_hold;

  // Next-state and starvation-count logic. The arbitration decision uses the
  // count this cycle will leave behind, so the grant that brings the count to
  // MAX_DWIN is the last dcache grant before the icache gets the port.
  always_comb begin
    drq        = dREN | dWEN;
    complete   = (state != IDLE) && ram_ready;
    burst_hold = (state == DGNT) && dlock && drq;

    cnt_next = starve_cnt;
    if (complete && (state == DGNT) && !burst_hold) begin
      if (iREN) begin
        cnt_next = (starve_cnt == MAX_CNT) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
        cnt_next = 4'd0;
      end
    end else if (complete && (state == IGNT)) begin
      cnt_next = 4'd0;
    end

    if (drq && !(iREN && (cnt_next == MAX_CNT))) begin
      arb_state = DGNT;
    end else if (iREN) begin
      arb_state = IGNT;
    end else begin
      arb_state = IDLE;
    end

    state_next = state;
    case (state)
      IDLE: state_next = arb_state;
      IGNT: begin
        if (ram_ready) begin
          state_next = arb_state;
        end else if (!iREN) begin
          state_next = IDLE;
        end
      end
      DGNT: begin
        if (ram_ready) begin
          state_next = burst_hold ? DGNT : arb_state;
        end else if (!drq) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and starvation counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
    end
  end

  // Datapath steering: only the current owner sees the RAM, and its wait
  // drops solely in the completion cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    case (state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (ram_ready) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (dWEN) begin
          ramWEN = 1'b1;
        end else begin
          ramREN = dREN;
        end
        if (ram_ready) begin
          dwait = 1'b0;
          dload = dWEN ? '0 : ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench for cache_mem_arbiter with
// hand-computed expected values checked by immediate assertions.
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dlock;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.ADDR_W(32), .MAX_DWIN(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One grant: check the owner's address, wait a cycle, then pulse ram_ready
  // and check the completion handshake; returns just after the next edge.
  task automatic grantCycle(input logic [31:0] expAddr, input bit expI);
    #1;
    check("gnt_addr", ramaddr, expAddr);
    check("gnt_ren", ramREN, 1);
    tick();
    ram_ready = 1'b1;
    #1;
    check("gnt_iwait", iwait, expI ? 0 : 1);
    check("gnt_dwait", dwait, expI ? 1 : 0);
    check("gnt_iload", iload, expI ? ramload : 0);
    check("gnt_dload", dload, expI ? 0 : ramload);
    tick();
    ram_ready = 1'b0;
  endtask

  initial begin
    // Reset with requests and ram_ready held high
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; dlock = 1'b0;
    iaddr = 32'h40; daddr = 32'h80; dstore = 32'h0; ramload = 32'h55;
    ram_ready = 1'b1;
    tick(); tick();
    check("rst_ramren", ramREN, 0);
    check("rst_ramwen", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);

    // Release reset: one cycle in IDLE, then dcache wins
    nRST = 1'b1; ram_ready = 1'b0;
    #1;
    check("idle_ramren", ramREN, 0);
    tick();
    check("first_dgnt_addr", ramaddr, 32'h80);
    check("first_dgnt_ren", ramREN, 1);
    check("first_dgnt_iwait", iwait, 1);
    // Abort: requests drop before ready, enables follow immediately
    iREN = 1'b0; dREN = 1'b0;
    #1;
    check("abort_ren_now", ramREN, 0);
    tick();
    check("abort_idle_ren", ramREN, 0);

    // icache read, ready two cycles after the grant
    iREN = 1'b1; iaddr = 32'h100; ramload = 32'hDEADBEEF;
    tick();
    check("ird_addr", ramaddr, 32'h100);
    check("ird_ren", ramREN, 1);
    check("ird_iwait_pre", iwait, 1);
    tick();
    check("ird_iwait_pre2", iwait, 1);
    ram_ready = 1'b1;
    #1;
    check("ird_iwait", iwait, 0);
    check("ird_iload", iload, 32'hDEADBEEF);
    check("ird_dwait", dwait, 1);
    tick();
    ram_ready = 1'b0; iREN = 1'b0;
    #1;
    check("ird_iwait_post", iwait, 1);
    check("ird_iload_post", iload, 0);
    tick();

    // dcache write with dREN also high: write wins
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
    ramload = 32'hAAAA5555;
    tick();
    check("dwr_wen", ramWEN, 1);
    check("dwr_ren", ramREN, 0);
    check("dwr_addr", ramaddr, 32'h200);
    check("dwr_store", ramstore, 32'h12345678);
    ram_ready = 1'b1;
    #1;
    check("dwr_dwait", dwait, 0);
    check("dwr_dload", dload, 0);
    check("dwr_iwait", iwait, 1);
    tick();
    ram_ready = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    #1;
    check("dwr_dwait_post", dwait, 1);
    tick();

    // Starvation: both held, grants D,D,D,D,I,D,D,D,D,I back to back
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h500; ramload = 32'h0BADF00D;
    tick();
    for (int g = 0; g < 10; g++) begin
      if ((g % 5) == 4) grantCycle(32'h400, 1'b1);
      else              grantCycle(32'h500, 1'b0);
    end
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // Locked burst entered with the counter at 3: the burst stays on the
    // dcache, then icache follows at once when the lock drops
    iREN = 1'b1; dREN = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) grantCycle(32'h500, 1'b0);
    dlock = 1'b1;
    for (int w = 0; w < 4; w++) begin
      daddr = 32'h300 + 32'(w * 4);
      if (w == 3) dlock = 1'b0;
      grantCycle(32'h300 + 32'(w * 4), 1'b0);
    end
    grantCycle(32'h400, 1'b1);
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // Reset in the middle of a dcache grant, then ram_ready pulses in IDLE
    dREN = 1'b1; daddr = 32'h600;
    tick();
    check("mrst_dgnt_ren", ramREN, 1);
    nRST = 1'b0;
    tick();
    check("mrst_ren", ramREN, 0);
    check("mrst_wen", ramWEN, 0);
    check("mrst_dwait", dwait, 1);
    nRST = 1'b1; dREN = 1'b0; ram_ready = 1'b1;
    #1;
    check("idle_rdy_iwait", iwait, 1);
    check("idle_rdy_dwait", dwait, 1);
    check("idle_rdy_ren", ramREN, 0);
    tick();
    check("idle_rdy2_iwait", iwait, 1);
    check("idle_rdy2_dwait", dwait, 1);
    check("idle_rdy2_dload", dload, 0);
    ram_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
